pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch-stage program counter generator for the pipelined CPU; successor to the fixed 32-bit PC register. Produces the fetch PC every cycle from four sources (exception entry, ERET return, branch/jump redirect, sequential step), holds under stall, and buffers a redirect that arrives while stalled so that it is never lost. It also reports misalignment of the current PC and keeps a saturating count of applied redirects for performance monitoring.

## Interface
- WIDTH, 32, PC width in bits (≥ 8)
- RESET_VEC, 32'h0000_3000, PC value after reset (WIDTH bits)
- EXC_VEC, 32'h0000_4180, exception handler entry address
- STEP, 4, sequential increment in bytes
- CNT_W, 16, redirect counter width
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- stall  in  1  hold PC this cycle
- br_valid  in  1  branch/jump redirect request
- br_target  in  WIDTH  branch/jump target
- eret_valid  in  1  exception return request
- epc  in  WIDTH  ERET return address
- exc_valid  in  1  exception entry request (target EXC_VEC)
- pc  out  WIDTH  current fetch PC (registered)
- pc_misaligned  out  1  pc[1:0] != 2'b00
- redirect_pending  out  1  a buffered redirect awaits stall release
- redirect_cnt  out  CNT_W  number of redirects applied, saturating

## Operation
- Priority within a cycle: exc > eret > br > sequential. Combined request = highest valid source with its target.
- Not stalled, no pending: pc <= combined target if any request, else pc + STEP.
- Not stalled, pending set: pending competes with current-cycle request by priority; on equal priority current wins; pc <= winner; pending cleared.
- Stalled: pc holds. A current request is captured into pending if pending empty, or if its priority ≥ the stored one (newest wins on tie); lower priority request dropped. pending_prio and pending_target are stored.
- Sequential arithmetic: pc + STEP modulo 2^WIDTH (0xFFFF_FFFC + 4 -> 0x0000_0000, no flag).
- Misaligned targets loaded unchanged; pc_misaligned flags them (exception raised downstream, not here).
- redirect_cnt increments by 1 on every cycle where pc is loaded from a redirect (current or pending); capture into pending does not count; holds at 2^CNT_W − 1.
- redirect_pending = pending valid bit.

## Timing
- Reset (reset_n low at edge): pc = RESET_VEC, pending cleared, redirect_cnt = 0, redirect_pending = 0, pc_misaligned = RESET_VEC[1:0] != 0. Reset overrides stall and every request, including mid-stall with pending set.
- Redirect latency: request in cycle N, not stalled -> pc = target after edge N.
- Stall release: stall low in cycle M with pending -> pc = pending (or higher-priority current) target after edge M.
- pc_misaligned combinational from pc register; no extra latency.
- No handshake back-pressure: requests are single-cycle pulses, sampled every edge.

## Structure
- Package pc_pkg: redir_prio_t enum {PRIO_NONE=0, PRIO_BR=1, PRIO_ERET=2, PRIO_EXC=3}; default RESET_VEC, EXC_VEC constants.
- Sub-module pc_redirect_sel: purely combinational priority select of (prio, target) over two candidates with tie rule "second argument wins"; instantiated twice (current sources, current vs pending).
- Top holds pc register, pending register, counter.

## Test plan
- Reset then 3 free-running cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; redirect_cnt 0.
- br_valid=1, br_target=0x3100 together with exc_valid=1 -> next pc 0x4180; redirect_cnt 1.
- stall high 3 cycles, br to 0x3200 in cycle 1, eret epc 0x3050 in cycle 2 -> pc held, redirect_pending=1; on release pc 0x3050, redirect_cnt +1 only.
- pc = 0xFFFF_FFFC (via br) then sequential -> pc 0x0000_0000; br_target 0x3002 -> pc_misaligned=1.
- reset_n low during stall with pending set -> pc 0x3000, redirect_pending 0, redirect_cnt 0.
- CNT_W=2, 5 consecutive redirects -> redirect_cnt 1,2,3,3,3.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage PC generator.
// Redirect priorities are ordered so that a numeric compare gives precedence.
package pc_pkg;

  typedef enum logic [1:0] {
    PRIO_NONE = 2'd0,
    PRIO_BR   = 2'd1,
    PRIO_ERET = 2'd2,
    PRIO_EXC  = 2'd3
  } redir_prio_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam int unsigned DEF_STEP      = 32'd4;
  localparam int unsigned DEF_CNT_W     = 32'd16;

  // Instruction fetch requires word alignment.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational priority select between two redirect candidates.
// On equal priority the second candidate (b) wins.
module pc_redirect_sel
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  redir_prio_t      a_prio_i,
  input  logic [WIDTH-1:0] a_target_i,
  input  redir_prio_t      b_prio_i,
  input  logic [WIDTH-1:0] b_target_i,
  output redir_prio_t      prio_o,
  output logic [WIDTH-1:0] target_o
);

  // Pick the higher-priority candidate, b on a tie.
  always_comb begin
    prio_o   = PRIO_NONE;
    target_o = '0;
    if (b_prio_i >= a_prio_i) begin
      prio_o   = b_prio_i;
      target_o = b_target_i;
    end else begin
      prio_o   = a_prio_i;
      target_o = a_target_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: exception/ERET/branch redirects, sequential step,
// stall hold with a one-entry redirect buffer, and a saturating redirect counter.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int unsigned     STEP      = DEF_STEP,
  parameter int unsigned     CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] epc,
  input  logic             exc_valid,
  output logic [WIDTH-1:0] pc,
  output logic             pc_misaligned,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  redir_prio_t      pend_prio_q, pend_prio_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  redir_prio_t      br_prio_s, hi_prio_s, cur_prio_s, win_prio_s;
  logic [WIDTH-1:0] hi_tgt_s, cur_tgt_s, win_tgt_s;

  // Exception outranks ERET; branch is merged below by the shared selector.
  always_comb begin
    hi_prio_s = PRIO_NONE;
    hi_tgt_s  = '0;
    if (exc_valid) begin
      hi_prio_s = PRIO_EXC;
      hi_tgt_s  = EXC_VEC;
    end else if (eret_valid) begin
      hi_prio_s = PRIO_ERET;
      hi_tgt_s  = epc;
    end else begin
      hi_prio_s = PRIO_NONE;
      hi_tgt_s  = '0;
    end
  end

  assign br_prio_s = br_valid ? PRIO_BR : PRIO_NONE;

  pc_redirect_sel #(.WIDTH(WIDTH)) u_cur_sel (
    .a_prio_i   (br_prio_s),
    .a_target_i (br_target),
    .b_prio_i   (hi_prio_s),
    .b_target_i (hi_tgt_s),
    .prio_o     (cur_prio_s),
    .target_o   (cur_tgt_s)
  );

  // Current request is second so it wins ties: newest-wins while stalled,
  // current-wins on release.
  pc_redirect_sel #(.WIDTH(WIDTH)) u_win_sel (
    .a_prio_i   (pend_prio_q),
    .a_target_i (pend_tgt_q),
    .b_prio_i   (cur_prio_s),
    .b_target_i (cur_tgt_s),
    .prio_o     (win_prio_s),
    .target_o   (win_tgt_s)
  );

  // Next-state: hold and buffer under stall, otherwise apply winner or step.
  always_comb begin
    pc_d        = pc_q;
    pend_prio_d = pend_prio_q;
    pend_tgt_d  = pend_tgt_q;
    cnt_d       = cnt_q;
    if (stall) begin
      pend_prio_d = win_prio_s;
      pend_tgt_d  = win_tgt_s;
    end else begin
      pend_prio_d = PRIO_NONE;
      pend_tgt_d  = '0;
      if (win_prio_s != PRIO_NONE) begin
        pc_d = win_tgt_s;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        pc_d = pc_q + STEP_W;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q        <= RESET_VEC;
      pend_prio_q <= PRIO_NONE;
      pend_tgt_q  <= '0;
      cnt_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_prio_q <= pend_prio_d;
      pend_tgt_q  <= pend_tgt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc               = pc_q;
  assign pc_misaligned    = is_misaligned(pc_q[1:0]);
  assign redirect_pending = (pend_prio_q != PRIO_NONE);
  assign redirect_cnt     = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: default instance plus a CNT_W=2 instance for saturation.
module tb_pc_gen;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        eret_valid;
  logic [31:0] epc;
  logic        exc_valid;

  logic [31:0] pc;
  logic        pc_misaligned;
  logic        redirect_pending;
  logic [15:0] redirect_cnt;

  logic [31:0] pc2;
  logic        pc_misaligned2;
  logic        redirect_pending2;
  logic [1:0]  redirect_cnt2;

  int n_cmp;
  int n_mis;

  pc_gen dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .eret_valid       (eret_valid),
    .epc              (epc),
    .exc_valid        (exc_valid),
    .pc               (pc),
    .pc_misaligned    (pc_misaligned),
    .redirect_pending (redirect_pending),
    .redirect_cnt     (redirect_cnt)
  );

  pc_gen #(.CNT_W(2)) dut2 (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .eret_valid       (eret_valid),
    .epc              (epc),
    .exc_valid        (exc_valid),
    .pc               (pc2),
    .pc_misaligned    (pc_misaligned2),
    .redirect_pending (redirect_pending2),
    .redirect_cnt     (redirect_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp = n_cmp + 1;
    if (obs !== exp_v) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    br_valid   = 1'b0;
    eret_valid = 1'b0;
    exc_valid  = 1'b0;
    br_target  = 32'h0;
    epc        = 32'h0;
  endtask

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    reset_n = 1'b0;
    stall   = 1'b0;
    clear_req();
    tick();
    tick();
    check_val("rst_pc", pc, 32'h0000_3000);
    check_val("rst_cnt", {16'h0, redirect_cnt}, 32'h0);
    check_val("rst_pend", {31'h0, redirect_pending}, 32'h0);
    check_val("rst_mis", {31'h0, pc_misaligned}, 32'h0);
    reset_n = 1'b1;

    // Free-running sequential steps
    tick(); check_val("seq1", pc, 32'h0000_3004);
    tick(); check_val("seq2", pc, 32'h0000_3008);
    tick(); check_val("seq3", pc, 32'h0000_300C);
    check_val("seq_cnt", {16'h0, redirect_cnt}, 32'h0);

    // Exception beats branch in the same cycle
    br_valid = 1'b1; br_target = 32'h0000_3100; exc_valid = 1'b1;
    tick(); clear_req();
    check_val("exc_pc", pc, 32'h0000_4180);
    check_val("exc_cnt", {16'h0, redirect_cnt}, 32'd1);

    // Stall: branch then ERET buffered; ERET wins on release
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3200;
    tick(); clear_req();
    check_val("stall1_pc", pc, 32'h0000_4180);
    check_val("stall1_pend", {31'h0, redirect_pending}, 32'd1);
    eret_valid = 1'b1; epc = 32'h0000_3050;
    tick(); clear_req();
    check_val("stall2_pc", pc, 32'h0000_4180);
    tick();
    check_val("stall3_pc", pc, 32'h0000_4180);
    check_val("stall3_pend", {31'h0, redirect_pending}, 32'd1);
    check_val("stall3_cnt", {16'h0, redirect_cnt}, 32'd1);
    stall = 1'b0;
    tick();
    check_val("rel_pc", pc, 32'h0000_3050);
    check_val("rel_cnt", {16'h0, redirect_cnt}, 32'd2);
    check_val("rel_pend", {31'h0, redirect_pending}, 32'd0);
    tick();
    check_val("rel_seq", pc, 32'h0000_3054);

    // Wrap-around and misaligned target
    br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
    tick(); clear_req();
    check_val("wrap_pre", pc, 32'hFFFF_FFFC);
    tick();
    check_val("wrap_pc", pc, 32'h0000_0000);
    check_val("wrap_cnt", {16'h0, redirect_cnt}, 32'd3);
    br_valid = 1'b1; br_target = 32'h0000_3002;
    tick(); clear_req();
    check_val("mis_pc", pc, 32'h0000_3002);
    check_val("mis_flag", {31'h0, pc_misaligned}, 32'd1);
    check_val("mis_cnt", {16'h0, redirect_cnt}, 32'd4);

    // Lower-priority branch dropped while exception pending
    stall = 1'b1; exc_valid = 1'b1;
    tick(); clear_req();
    br_valid = 1'b1; br_target = 32'h0000_3500;
    tick(); clear_req();
    check_val("drop_hold", pc, 32'h0000_3002);
    stall = 1'b0;
    tick();
    check_val("drop_pc", pc, 32'h0000_4180);
    check_val("drop_cnt", {16'h0, redirect_cnt}, 32'd5);

    // Higher-priority current request beats pending on release
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3300;
    tick(); clear_req();
    stall = 1'b0; eret_valid = 1'b1; epc = 32'h0000_3060;
    tick(); clear_req();
    check_val("cur_win_pc", pc, 32'h0000_3060);
    check_val("cur_win_cnt", {16'h0, redirect_cnt}, 32'd6);

    // Equal priority while stalled: newest wins
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3600;
    tick();
    br_target = 32'h0000_3700;
    tick(); clear_req();
    stall = 1'b0;
    tick();
    check_val("tie_pc", pc, 32'h0000_3700);
    check_val("tie_cnt", {16'h0, redirect_cnt}, 32'd7);

    // Equal priority on release: current wins over pending
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3800;
    tick();
    stall = 1'b0; br_target = 32'h0000_3900;
    tick(); clear_req();
    check_val("rel_tie_pc", pc, 32'h0000_3900);

    // Reset mid-stall with pending set
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3400;
    tick();
    check_val("pre_rst_pend", {31'h0, redirect_pending}, 32'd1);
    reset_n = 1'b0;
    tick(); clear_req();
    check_val("mrst_pc", pc, 32'h0000_3000);
    check_val("mrst_pend", {31'h0, redirect_pending}, 32'd0);
    check_val("mrst_cnt", {16'h0, redirect_cnt}, 32'd0);
    reset_n = 1'b1; stall = 1'b0;

    // Saturation on the 2-bit counter instance
    for (int i = 1; i <= 5; i++) begin
      br_valid = 1'b1; br_target = 32'h0000_3000 + 32'(i) * 32'h10;
      tick();
      check_val($sformatf("sat_cnt%0d", i), {30'h0, redirect_cnt2}, (i < 3) ? 32'(i) : 32'd3);
      check_val($sformatf("wide_cnt%0d", i), {16'h0, redirect_cnt}, 32'(i));
    end
    clear_req();
    check_val("sat_pc", pc2, 32'h0000_3050);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
